// File: rtl/rtf_nimplus_pkg.sv
// Shared types and constants for the RTF_NIMPlus host register path.
// Burst-length normalisation lives here so request decode stays readable.
package rtf_nimplus_pkg;

    typedef logic [63:0] reg_word_t;

    localparam int        RD_FLAG_BIT = 31;
    localparam reg_word_t BAD_WORD    = 64'hBAD0_BAD0_BAD0_BAD0;
    localparam int        MAX_BURST   = 16;

    typedef enum logic {
        IDLE,
        READ
    } rd_state_t;

    // A zero length field means one word; anything above MAX_BURST is clipped.
    function automatic logic [4:0] burst_len(input logic [4:0] req);
        if (req == 5'd0)
            return 5'd1;
        if (req > 5'(MAX_BURST))
            return 5'(MAX_BURST);
        return req;
    endfunction

endpackage

// File: rtl/eth_tx_fifo.sv
// Synchronous show-ahead FIFO: dout presents the head word straight from storage.
// A push while full is taken only when a pop frees a slot in the same cycle.
module eth_tx_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [CW-1:0]    count;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    // Storage needs no reset: the head is masked whenever the FIFO is empty.
    always_ff @(posedge clk) begin
        if (do_push)
            mem[wr_ptr] <= din;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push)
                wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)
                rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign dout = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/eth_reg_responder.sv
// Host-link register responder: write beats update a 64-bit register bank, read
// requests stream a burst of register words into the show-ahead TX FIFO.
module eth_reg_responder
    import rtf_nimplus_pkg::*;
#(
    parameter int NREGS      = 16,
    parameter int ADDR_BITS  = 8,
    parameter int FIFO_DEPTH = 32
) (
    input  logic               MASTER_CLK,
    input  logic               reset_n,
    input  logic               rx_wren,
    input  logic [31:0]        rx_addr,
    input  logic [63:0]        rx_data,
    input  logic               tx_rden,
    output logic [63:0]        tx_data,
    output logic               tx_empty,
    output logic               user_ready,
    output logic [NREGS*64-1:0] reg_q,
    output logic [NREGS-1:0]   wr_strobe,
    output logic [15:0]        err_cnt
);

    localparam int RIDX_W = $clog2(NREGS);

    reg_word_t             regs [NREGS];
    rd_state_t             state;
    rd_state_t             state_next;
    logic [ADDR_BITS-1:0]  cur_idx;
    logic [ADDR_BITS-1:0]  cur_idx_next;
    logic [4:0]            remaining;
    logic [4:0]            remaining_next;

    logic [ADDR_BITS-1:0]  wr_idx;
    logic                  wr_in_range;
    logic                  wr_ok;
    logic                  wr_bad;
    logic                  rd_req;
    logic                  rd_drop;
    logic [NREGS-1:0]      wr_onehot;

    logic                  rd_in_range;
    reg_word_t             rd_word;
    logic                  fifo_push;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic                  err_any;
    logic                  unused_addr;

    assign unused_addr = ^rx_addr[30:ADDR_BITS];

    assign wr_idx      = rx_addr[ADDR_BITS-1:0];
    assign wr_in_range = (32'(wr_idx) < 32'(NREGS));
    assign wr_ok       = rx_wren && !rx_addr[RD_FLAG_BIT] && wr_in_range;
    assign wr_bad      = rx_wren && !rx_addr[RD_FLAG_BIT] && !wr_in_range;
    assign rd_req      = rx_wren && rx_addr[RD_FLAG_BIT];

    always_comb begin
        wr_onehot = '0;
        wr_onehot[wr_idx[RIDX_W-1:0]] = wr_ok;
    end

    // Readback samples the bank before this edge's write lands, so a same-cycle
    // write to the word being pushed yields the old value.
    assign rd_in_range = (32'(cur_idx) < 32'(NREGS));
    assign rd_word     = rd_in_range ? regs[cur_idx[RIDX_W-1:0]] : BAD_WORD;

    always_ff @(posedge MASTER_CLK or negedge reset_n) begin
        if (!reset_n) begin
            for (int unsigned i = 0; i < NREGS; i++)
                regs[i] <= '0;
            wr_strobe <= '0;
        end else begin
            wr_strobe <= wr_onehot;
            if (wr_ok)
                regs[wr_idx[RIDX_W-1:0]] <= rx_data;
        end
    end

    always_comb begin
        for (int unsigned i = 0; i < NREGS; i++)
            reg_q[64*i +: 64] = regs[i];
    end

    always_ff @(posedge MASTER_CLK or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            cur_idx   <= '0;
            remaining <= '0;
        end else begin
            state     <= state_next;
            cur_idx   <= cur_idx_next;
            remaining <= remaining_next;
        end
    end

    // A full FIFO still accepts a push when the interface pops in the same cycle.
    always_comb begin
        state_next     = state;
        cur_idx_next   = cur_idx;
        remaining_next = remaining;
        fifo_push      = 1'b0;
        rd_drop        = 1'b0;
        case (state)
            IDLE: begin
                if (rd_req) begin
                    cur_idx_next   = rx_addr[ADDR_BITS-1:0];
                    remaining_next = burst_len(rx_data[4:0]);
                    state_next     = READ;
                end
            end
            READ: begin
                rd_drop = rd_req;
                if (!fifo_full || tx_rden) begin
                    fifo_push      = 1'b1;
                    cur_idx_next   = cur_idx + 1'b1;
                    remaining_next = remaining - 5'd1;
                    if (remaining == 5'd1)
                        state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    eth_tx_fifo #(
        .WIDTH (64),
        .DEPTH (FIFO_DEPTH)
    ) u_tx_fifo (
        .clk   (MASTER_CLK),
        .rst_n (reset_n),
        .push  (fifo_push),
        .pop   (tx_rden),
        .din   (rd_word),
        .dout  (tx_data),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign tx_empty   = fifo_empty;
    assign user_ready = (state == IDLE);

    // Several error sources in one cycle still count once.
    assign err_any = wr_bad || rd_drop || (tx_rden && fifo_empty);

    always_ff @(posedge MASTER_CLK or negedge reset_n) begin
        if (!reset_n)
            err_cnt <= '0;
        else if (err_any && (err_cnt != '1))
            err_cnt <= err_cnt + 16'd1;
    end

endmodule

// File: tb/tb_eth_reg_responder.sv
// Directed bench for eth_reg_responder: a transaction-level model (register array,
// word queue, error counter) is compared against the DUT every cycle, plus literal checks.
module tb_eth_reg_responder;
    import rtf_nimplus_pkg::*;

    localparam int NREGS      = 16;
    localparam int ADDR_BITS  = 8;
    localparam int FIFO_DEPTH = 32;
    localparam logic [63:0] NEW5 = 64'hDEAD_BEEF_0000_0005;

    logic                  clk = 1'b0;
    logic                  rst_n = 1'b0;
    logic                  rx_wren = 1'b0;
    logic [31:0]           rx_addr = '0;
    logic [63:0]           rx_data = '0;
    logic                  tx_rden = 1'b0;
    logic [63:0]           tx_data;
    logic                  tx_empty;
    logic                  user_ready;
    logic [NREGS*64-1:0]   reg_q;
    logic [NREGS-1:0]      wr_strobe;
    logic [15:0]           err_cnt;

    eth_reg_responder #(
        .NREGS      (NREGS),
        .ADDR_BITS  (ADDR_BITS),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .MASTER_CLK (clk),
        .reset_n    (rst_n),
        .rx_wren    (rx_wren),
        .rx_addr    (rx_addr),
        .rx_data    (rx_data),
        .tx_rden    (tx_rden),
        .tx_data    (tx_data),
        .tx_empty   (tx_empty),
        .user_ready (user_ready),
        .reg_q      (reg_q),
        .wr_strobe  (wr_strobe),
        .err_cnt    (err_cnt)
    );

    always #5 clk = ~clk;

    int n_total = 0;
    int n_pass  = 0;
    bit cmp_en  = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp)
            n_pass++;
        else
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    // Model: registers, queued words, and an active burst (next index, words left).
    logic [63:0]      m_regs [NREGS];
    logic [63:0]      m_q [$];
    bit               m_busy;
    int               m_idx;
    int               m_left;
    int               m_err;
    logic [NREGS-1:0] m_strobe;
    bit               e_err;
    bit               e_was_busy;
    bit               e_popped;
    int               e_size;
    int               e_widx;
    int               e_len;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            foreach (m_regs[i]) m_regs[i] = '0;
            m_q.delete();
            m_busy   = 1'b0;
            m_idx    = 0;
            m_left   = 0;
            m_err    = 0;
            m_strobe = '0;
        end else begin
            e_err      = 1'b0;
            e_was_busy = m_busy;
            e_size     = m_q.size();
            e_popped   = 1'b0;
            if (tx_rden) begin
                if (e_size > 0) begin
                    void'(m_q.pop_front());
                    e_popped = 1'b1;
                end else begin
                    e_err = 1'b1;
                end
            end
            if (e_was_busy && (e_size < FIFO_DEPTH || e_popped)) begin
                m_q.push_back((m_idx < NREGS) ? m_regs[m_idx] : BAD_WORD);
                m_idx  = (m_idx + 1) % 256;
                m_left = m_left - 1;
                if (m_left == 0)
                    m_busy = 1'b0;
            end
            m_strobe = '0;
            e_widx   = int'(rx_addr[7:0]);
            if (rx_wren && !rx_addr[31]) begin
                if (e_widx < NREGS) begin
                    m_regs[e_widx]   = rx_data;
                    m_strobe[e_widx] = 1'b1;
                end else begin
                    e_err = 1'b1;
                end
            end
            if (rx_wren && rx_addr[31]) begin
                if (e_was_busy) begin
                    e_err = 1'b1;
                end else begin
                    e_len  = int'(rx_data[4:0]);
                    m_busy = 1'b1;
                    m_idx  = e_widx;
                    m_left = (e_len == 0) ? 1 : ((e_len > MAX_BURST) ? MAX_BURST : e_len);
                end
            end
            if (e_err && m_err < 65535)
                m_err++;
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            check("tx_empty", 64'(tx_empty), 64'(m_q.size() == 0));
            check("user_ready", 64'(user_ready), 64'(!m_busy));
            check("err_cnt", 64'(err_cnt), 64'(m_err));
            check("wr_strobe", 64'(wr_strobe), 64'(m_strobe));
            if (m_q.size() > 0)
                check("tx_data", tx_data, m_q[0]);
            for (int i = 0; i < NREGS; i++)
                check($sformatf("reg_q[%0d]", i), reg_q[64*i +: 64], m_regs[i]);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input int idx, input logic [63:0] d);
        rx_wren = 1'b1;
        rx_addr = 32'(idx);
        rx_data = d;
        tick();
        rx_wren = 1'b0;
        rx_addr = '0;
        rx_data = '0;
    endtask

    task automatic rd(input int start, input int len);
        rx_wren = 1'b1;
        rx_addr = 32'h8000_0000 | 32'(start);
        rx_data = 64'(len);
        tick();
        rx_wren = 1'b0;
        rx_addr = '0;
        rx_data = '0;
    endtask

    task automatic wait_idle();
        bit done;
        done = 1'b0;
        for (int c = 0; c < 200 && !done; c++) begin
            if (user_ready)
                done = 1'b1;
            else
                tick();
        end
        if (!done)
            check("wait_idle_timeout", 64'(0), 64'(1));
    endtask

    logic [63:0] got [$];

    task automatic drain();
        bit done;
        done = 1'b0;
        got.delete();
        for (int c = 0; c < 400 && !done; c++) begin
            if (!tx_empty) begin
                got.push_back(tx_data);
                tx_rden = 1'b1;
            end else begin
                tx_rden = 1'b0;
                if (user_ready)
                    done = 1'b1;
            end
            if (!done)
                tick();
        end
        tx_rden = 1'b0;
        if (!done)
            check("drain_timeout", 64'(0), 64'(1));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("rst_tx_empty", 64'(tx_empty), 64'(1));
        check("rst_user_ready", 64'(user_ready), 64'(1));
        check("rst_err_cnt", 64'(err_cnt), 64'(0));
        check("rst_tx_data", tx_data, 64'(0));
        check("rst_reg_q", 64'(|reg_q), 64'(0));
        rst_n  = 1'b1;
        cmp_en = 1'b1;
        tick();

        // Single write then single-word read.
        wr(3, 64'h0123_4567_89AB_CDEF);
        check("t1_strobe", 64'(wr_strobe), 64'h0008);
        check("t1_reg3", reg_q[64*3 +: 64], 64'h0123_4567_89AB_CDEF);
        tick();
        check("t1_strobe_clear", 64'(wr_strobe), 64'h0000);
        rd(3, 1);
        check("t1_empty_after_req", 64'(tx_empty), 64'(1));
        check("t1_busy", 64'(user_ready), 64'(0));
        tick();
        check("t1_empty_falls", 64'(tx_empty), 64'(0));
        check("t1_tx_data", tx_data, 64'h0123_4567_89AB_CDEF);
        drain();
        check("t1_count", 64'(got.size()), 64'(1));

        // Fill bank, read across the end of the bank and across the index wrap.
        for (int i = 0; i < NREGS; i++)
            wr(i, 64'(i * 32'h1111));
        rd(14, 4);
        drain();
        check("t2_count", 64'(got.size()), 64'(4));
        check("t2_w0", got[0], 64'hEEEE);
        check("t2_w1", got[1], 64'hFFFF);
        check("t2_w2", got[2], 64'hBAD0_BAD0_BAD0_BAD0);
        check("t2_w3", got[3], 64'hBAD0_BAD0_BAD0_BAD0);
        rd(255, 2);
        drain();
        check("t2_wrap_w0", got[0], 64'hBAD0_BAD0_BAD0_BAD0);
        check("t2_wrap_w1", got[1], 64'h0);

        // Length normalisation and request-while-busy.
        rd(0, 0);
        drain();
        check("t4_len0", 64'(got.size()), 64'(1));
        rd(0, 31);
        rd(2, 1);
        check("t4_err", 64'(err_cnt), 64'(1));
        drain();
        check("t4_len31", 64'(got.size()), 64'(16));

        // Pop on empty, then same-cycle push and write of the same register.
        tx_rden = 1'b1;
        tick();
        tx_rden = 1'b0;
        check("t5_err_empty_pop", 64'(err_cnt), 64'(2));
        check("t5_still_empty", 64'(tx_empty), 64'(1));
        rd(5, 1);
        wr(5, NEW5);
        check("t5_reg5_new", reg_q[64*5 +: 64], NEW5);
        drain();
        check("t5_count", 64'(got.size()), 64'(1));
        check("t5_old_word", got[0], 64'h5555);

        // Fill to full, drop a request while busy, stall, push+pop at full.
        rd(0, 16);
        wait_idle();
        rd(0, 16);
        repeat (3) tick();
        rd(0, 4);
        check("t3_err_drop", 64'(err_cnt), 64'(3));
        wait_idle();
        check("t3_full_not_empty", 64'(tx_empty), 64'(0));
        rd(5, 2);
        repeat (4) tick();
        check("t3_stalled", 64'(user_ready), 64'(0));
        tx_rden = 1'b1;
        tick();
        tx_rden = 1'b0;
        repeat (2) tick();
        check("t3_still_stalled", 64'(user_ready), 64'(0));
        drain();
        check("t3_count", 64'(got.size()), 64'(33));
        check("t3_first", got[0], 64'h1111);
        check("t3_push_at_full", got[31], NEW5);
        check("t3_last", got[32], 64'h6666);

        // Reset in the middle of a burst.
        rd(0, 16);
        repeat (8) tick();
        rst_n = 1'b0;
        #1;
        check("t6_rst_empty", 64'(tx_empty), 64'(1));
        check("t6_rst_ready", 64'(user_ready), 64'(1));
        check("t6_rst_err", 64'(err_cnt), 64'(0));
        check("t6_rst_tx_data", tx_data, 64'(0));
        check("t6_rst_reg_q", 64'(|reg_q), 64'(0));
        check("t6_rst_strobe", 64'(wr_strobe), 64'(0));
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
        check("t6_post_empty", 64'(tx_empty), 64'(1));
        check("t6_post_ready", 64'(user_ready), 64'(1));
        rd(0, 1);
        drain();
        check("t6_read_count", 64'(got.size()), 64'(1));
        check("t6_read_word", got[0], 64'h0);
        wr(32'h20, 64'h1234);
        check("t6_bad_write_err", 64'(err_cnt), 64'(1));
        check("t6_bad_write_dropped", 64'(|reg_q), 64'(0));
        tick();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
